cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus arbiter sharing one result broadcast bus among the out-of-order core's result producers: the scalar-ALU reservation station, the load/store buffer and the multiply/divide unit. Each producer pushes `(rob_id, value)` results into a small per-source FIFO inside this block. A round-robin scheduler drains one result per cycle onto a registered CDB that feeds the ROB, the reservation stations and the LSB wake-up logic. A flush input discards all pending results on misprediction.

## Interface
- `N_SRC`, default 3: number of producers (index 0 = ALU RS, 1 = LSB, 2 = MDU).
- `ROB_WIDTH_BIT`, default `` `ROB_WIDTH_BIT ``: ROB tag width.
- `FIFO_DEPTH_BIT`, default 1: log2 of entries per source FIFO (default 2 entries).
- `clk_in` input 1: the single clock; all state on its rising edge.
- `rst_in` input 1: reset, asynchronous, active-low.
- `rdy_in` input 1: pause; when low, all state holds.
- `flush` input 1: misprediction flush.
- `src_valid` input N_SRC: per-source push request.
- `src_rob_id` input N_SRC*ROB_WIDTH_BIT: packed tags, source i at bits [i*W +: W].
- `src_value` input N_SRC*32: packed results, source i at bits [i*32 +: 32].
- `src_ready` output N_SRC: per-source FIFO can accept.
- `cdb_valid` output 1: broadcast valid this cycle.
- `cdb_rob_id` output ROB_WIDTH_BIT: broadcast tag.
- `cdb_value` output 32: broadcast value.

## Operation
- Per-source circular FIFO: head and tail pointers of FIFO_DEPTH_BIT bits each, plus a count of FIFO_DEPTH_BIT+1 bits. Pointers wrap modulo 2^FIFO_DEPTH_BIT.
- `src_ready[i] = rdy_in && count[i] < 2^FIFO_DEPTH_BIT`. It depends on registered state only; a same-cycle pop does not free a slot.
- Push i: `src_valid[i] && src_ready[i] && !flush`. Pushes with `src_ready` low are ignored; the producer must hold the result.
- Eligible set: all sources with `count[i] != 0`.
- Round-robin: register `last_grant` (reset 0). Search starts at `last_grant+1 mod N_SRC`; the first eligible source wins. `last_grant` updates only when a grant occurs.
- On a grant, the winner's head entry is registered into the `cdb_*` outputs, that head pointer increments, and `cdb_valid <= 1`. With no grant, `cdb_valid <= 0` and `cdb_rob_id`/`cdb_value` hold their old values.
- Push and pop on the same FIFO in one cycle: count unchanged, both pointers advance.
- Flush: all counts and pointers go to 0 and `cdb_valid <= 0`. Pushes in the flush cycle are dropped. `last_grant` is kept.
- `rdy_in` low: no push, pop, grant or pointer change. `cdb_*` hold. Consumers are also paused, so no duplicate broadcast results.
- Reset: all FIFOs empty, `last_grant=0`, `cdb_valid=0`, `cdb_rob_id=0`, `cdb_value=0`. `src_ready` reads `{N_SRC{rdy_in}}` during and after reset. Reset mid-operation discards everything immediately (asynchronous).

## Timing
- Without bypass: a push sampled at edge t is broadcast on `cdb_*` from edge t+1 at the earliest. It is visible during the cycle after t+1, i.e. 2 cycles of latency.
- With bypass (see Configuration): 1 cycle of latency.
- Throughput: exactly one broadcast per cycle while any FIFO is non-empty.
- Under continuous contention, each source waits at most N_SRC−1 grants.
- `cdb_*` are pure register outputs with no combinational path from inputs.

## Configuration
- `CDB_BYPASS_EN` defined: an empty FIFO whose push is valid counts as eligible in the same cycle. If it wins, the incoming `src_rob_id`/`src_value` load directly into the `cdb_*` registers and the FIFO is not written (pointers and count unchanged). Round-robin order is identical. Bypass is disabled in the flush cycle.
- Undefined: every result passes through its FIFO and only registered FIFO state is eligible.

## Test plan
- Single push: src 1 pushes tag 5, value 0xDEADBEEF at edge 0 → `cdb_valid=1`, tag 5, 0xDEADBEEF after edge 1. With `CDB_BYPASS_EN`, this appears after edge 0.
- Contention: all three sources push in the same cycle (tags 1, 2, 3) with `last_grant=0` → broadcast order tags 2, 3, 1 on consecutive cycles, then `cdb_valid=0`.
- Backpressure: src 0 pushes every cycle and the other sources stay idle, so src 0 drains every cycle and `src_ready[0]` stays 1. In a second case, srcs 1 and 2 also push every cycle; then src 0's FIFO reaches 2 entries, `src_ready[0]=0`, and no result is lost or duplicated (scoreboard all tags).
- Flush: fill src 2 with 2 entries, assert `flush` while src 0 pushes tag 7 → next cycle `cdb_valid=0`, all counts 0, tag 7 is never broadcast.
- Pause: hold `rdy_in=0` for 3 cycles with FIFOs non-empty → `cdb_*` and `src_ready=0` are frozen. After release, the broadcast sequence resumes exactly where it stopped.
- Async reset: drive `rst_in` low between edges with pending entries → `cdb_valid` drops to 0 immediately, and after release no stale entry is broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs drained round-robin onto a registered CDB.
// Optional CDB_BYPASS_EN lets an empty source's incoming push go straight to the bus.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module cdb_arbiter #(
    parameter int N_SRC          = 3,
    parameter int ROB_WIDTH_BIT  = `ROB_WIDTH_BIT,
    parameter int FIFO_DEPTH_BIT = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush,
    input  logic [N_SRC-1:0]             src_valid,
    input  logic [N_SRC*ROB_WIDTH_BIT-1:0] src_rob_id,
    input  logic [N_SRC*32-1:0]          src_value,
    output logic [N_SRC-1:0]             src_ready,
    output logic                         cdb_valid,
    output logic [ROB_WIDTH_BIT-1:0]     cdb_rob_id,
    output logic [31:0]                  cdb_value
);
    localparam int W     = ROB_WIDTH_BIT;
    localparam int FB    = FIFO_DEPTH_BIT;
    localparam int DEPTH = 1 << FB;
    localparam int GW    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [FB:0] DEPTH_C = (FB+1)'(DEPTH);

    logic [W-1:0]  mem_rob [N_SRC][DEPTH];
    logic [31:0]   mem_val [N_SRC][DEPTH];
    logic [FB-1:0] head_reg  [N_SRC];
    logic [FB-1:0] tail_reg  [N_SRC];
    logic [FB:0]   count_reg [N_SRC];
    logic [GW-1:0] last_grant_reg;
    logic          cdb_valid_reg;
    logic [W-1:0]  cdb_rob_id_reg;
    logic [31:0]   cdb_value_reg;

    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] pop;
    logic [N_SRC-1:0] write_en;
    logic             grant;
    logic [GW-1:0]    grant_idx;
    logic [GW:0]      idx;
    logic [W-1:0]     sel_rob;
    logic [31:0]      sel_val;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign src_ready[gi] = rdy_in && (count_reg[gi] < DEPTH_C);
            assign push[gi]      = src_valid[gi] && src_ready[gi] && !flush;
`ifdef CDB_BYPASS_EN
            assign eligible[gi]  = (count_reg[gi] != '0) || push[gi];
`else
            assign eligible[gi]  = (count_reg[gi] != '0);
`endif
            assign pop[gi]       = grant && (grant_idx == GW'(gi)) && (count_reg[gi] != '0);
            // A bypassed result (granted while its FIFO is empty) never enters the FIFO.
            assign write_en[gi]  = push[gi] && !(grant && (grant_idx == GW'(gi)) && (count_reg[gi] == '0));
        end
    endgenerate

    // Round-robin search starting one past the last winner.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = {1'b0, last_grant_reg} + (GW+1)'(k);
            if (idx >= (GW+1)'(N_SRC)) idx = idx - (GW+1)'(N_SRC);
            if (!grant && eligible[idx[GW-1:0]]) begin
                grant     = 1'b1;
                grant_idx = idx[GW-1:0];
            end
        end
        if (!rdy_in || flush) grant = 1'b0;
    end

    always_comb begin
        sel_rob = mem_rob[grant_idx][head_reg[grant_idx]];
        sel_val = mem_val[grant_idx][head_reg[grant_idx]];
`ifdef CDB_BYPASS_EN
        if (count_reg[grant_idx] == '0) begin
            sel_rob = src_rob_id[grant_idx*W +: W];
            sel_val = src_value[grant_idx*32 +: 32];
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (write_en[i]) begin
                mem_rob[i][tail_reg[i]] <= src_rob_id[i*W +: W];
                mem_val[i][tail_reg[i]] <= src_value[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                head_reg[i]  <= '0;
                tail_reg[i]  <= '0;
                count_reg[i] <= '0;
            end
            last_grant_reg <= '0;
            cdb_valid_reg  <= 1'b0;
            cdb_rob_id_reg <= '0;
            cdb_value_reg  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < N_SRC; i++) begin
                    head_reg[i]  <= '0;
                    tail_reg[i]  <= '0;
                    count_reg[i] <= '0;
                end
                cdb_valid_reg <= 1'b0;
            end else begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (write_en[i]) tail_reg[i] <= tail_reg[i] + 1'b1;
                    if (pop[i])      head_reg[i] <= head_reg[i] + 1'b1;
                    count_reg[i] <= count_reg[i] + (FB+1)'(write_en[i]) - (FB+1)'(pop[i]);
                end
                cdb_valid_reg <= grant;
                if (grant) begin
                    cdb_rob_id_reg <= sel_rob;
                    cdb_value_reg  <= sel_val;
                    last_grant_reg <= grant_idx;
                end
            end
        end
    end

    assign cdb_valid  = cdb_valid_reg;
    assign cdb_rob_id = cdb_rob_id_reg;
    assign cdb_value  = cdb_value_reg;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a queue-based reference model predicts broadcasts,
// a negedge monitor consumes each broadcast the paused-aware way the core's consumers do.
module tb_cdb_arbiter;
    localparam int N     = 3;
    localparam int W     = 6;
    localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             rdy_in = 1'b1;
    logic             flush  = 1'b0;
    logic [N-1:0]     src_valid = '0;
    logic [N*W-1:0]   src_rob_id = '0;
    logic [N*32-1:0]  src_value = '0;
    logic [N-1:0]     src_ready;
    logic             cdb_valid;
    logic [W-1:0]     cdb_rob_id;
    logic [31:0]      cdb_value;

    cdb_arbiter #(.N_SRC(N), .ROB_WIDTH_BIT(W), .FIFO_DEPTH_BIT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .src_valid(src_valid), .src_rob_id(src_rob_id), .src_value(src_value),
        .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [W-1:0] rob;
        logic [31:0]  val;
    } res_t;

    res_t fifo_q [N][$];
    res_t exp_q [$];
    int   last_grant = 0;
    int   total = 0;
    int   bad = 0;
    bit   seen_full = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = rdy_in && (fifo_q[i].size() < DEPTH);
        return r;
    endfunction

    // Reference model: per-source queues, rotating priority, one winner per active cycle.
    always @(posedge clk_in) begin : model_blk
        logic [N-1:0] push;
        res_t inc [N];
        int win, j;
        if (rst_in && rdy_in) begin
            if (flush) begin
                for (int i = 0; i < N; i++) fifo_q[i].delete();
            end else begin
                for (int i = 0; i < N; i++) begin
                    push[i] = src_valid[i] && (fifo_q[i].size() < DEPTH);
                    inc[i]  = {src_rob_id[i*W +: W], src_value[i*32 +: 32]};
                end
                win = -1;
                for (int k = 1; k <= N; k++) begin
                    j = (last_grant + k) % N;
`ifdef CDB_BYPASS_EN
                    if (win < 0 && (fifo_q[j].size() > 0 || push[j])) win = j;
`else
                    if (win < 0 && fifo_q[j].size() > 0) win = j;
`endif
                end
                if (win >= 0) begin
                    if (fifo_q[win].size() > 0) begin
                        exp_q.push_back(fifo_q[win].pop_front());
                    end else begin
                        exp_q.push_back(inc[win]);
                        push[win] = 1'b0;
                    end
                    last_grant = win;
                end
                for (int i = 0; i < N; i++) if (push[i]) fifo_q[i].push_back(inc[i]);
            end
        end
    end

    // Monitor: a broadcast is consumed at the next edge if rdy_in is high then.
    always @(negedge clk_in) begin : mon_blk
        res_t want;
        check("src_ready", src_ready, model_ready());
        if (!rst_in) begin
            check("valid_in_reset", cdb_valid, 1'b0);
        end else if (cdb_valid && rdy_in) begin
            if (exp_q.size() == 0) begin
                check("spurious_bcast", 1'b1, 1'b0);
            end else begin
                want = exp_q.pop_front();
                $display("bcast tag=%0d value=%08h (expected tag=%0d value=%08h)",
                         cdb_rob_id, cdb_value, want.rob, want.val);
                check("bcast", {cdb_rob_id, cdb_value}, want);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) fifo_q[i].delete();
        exp_q.delete();
        last_grant = 0;
    endtask

    task automatic set_src(int i, int tag, logic [31:0] val);
        src_valid[i] = 1'b1;
        src_rob_id[i*W +: W] = W'(tag);
        src_value[i*32 +: 32] = val;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        clear_model();
        step();
        rst_in = 1'b1;
    endtask

    task automatic drain(string name);
        bit busy;
        src_valid = '0;
        flush = 1'b0;
        rdy_in = 1'b1;
        busy = 1'b1;
        for (int c = 0; c < 40 && busy; c++) begin
            step();
            busy = exp_q.size() != 0;
            for (int i = 0; i < N; i++) if (fifo_q[i].size() != 0) busy = 1'b1;
        end
        check(name, busy, 1'b0);
    endtask

    initial begin
        #2;
        check("reset_valid", cdb_valid, 1'b0);
        check("reset_rob", cdb_rob_id, '0);
        check("reset_value", cdb_value, '0);
        check("reset_ready", src_ready, 3'b111);
        step();
        rst_in = 1'b1;
        step();

        // Single push
        set_src(1, 5, 32'hDEADBEEF);
        step();
        src_valid = '0;
        repeat (LAT-1) step();
        check("single_valid", cdb_valid, 1'b1);
        check("single_data", {cdb_rob_id, cdb_value}, {6'd5, 32'hDEADBEEF});
        drain("drain_single");

        // Contention from last_grant=0
        do_reset();
        set_src(0, 1, 32'h11);
        set_src(1, 2, 32'h22);
        set_src(2, 3, 32'h33);
        step();
        src_valid = '0;
        repeat (LAT-1) step();
        check("rr_first", cdb_rob_id, 6'd2);
        step();
        check("rr_second", cdb_rob_id, 6'd3);
        step();
        check("rr_third", cdb_rob_id, 6'd1);
        step();
        check("rr_idle", cdb_valid, 1'b0);

        // Backpressure: lone source never fills, then full contention
        for (int c = 0; c < 10; c++) begin
            set_src(0, 10 + c, 32'hA000_0000 + c);
            step();
            check("bp_alone_ready", src_ready[0], 1'b1);
        end
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) set_src(i, (c*3 + i) % 64, {8'(i), 24'(c)});
            step();
            if (!src_ready[0]) seen_full = 1'b1;
        end
        check("bp_src0_filled", seen_full, 1'b1);
        drain("drain_bp");

        // Flush with src 2 backlog while src 0 pushes tag 7
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) set_src(i, 20 + c*3 + i, 32'hF00 + c*3 + i);
            step();
        end
        src_valid = '0;
        set_src(0, 7, 32'h7777);
        flush = 1'b1;
        step();
        flush = 1'b0;
        src_valid = '0;
        check("flush_valid", cdb_valid, 1'b0);
        check("flush_ready", src_ready, 3'b111);
        drain("drain_flush");

        // Pause with pending results
        for (int i = 0; i < N; i++) set_src(i, 30 + i, 32'hB0 + i);
        step();
        src_valid = '0;
        step();
        rdy_in = 1'b0;
        repeat (3) step();
        rdy_in = 1'b1;
        drain("drain_pause");

        // Asynchronous reset between edges with pending entries
        for (int i = 0; i < N; i++) set_src(i, 40 + i, 32'hC0 + i);
        step();
        src_valid = '0;
        step();
        #2;
        rst_in = 1'b0;
        clear_model();
        #1;
        check("async_reset_valid", cdb_valid, 1'b0);
        step();
        rst_in = 1'b1;
        drain("drain_reset");

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                src_valid[i] = $urandom_range(0, 1) == 1;
                src_rob_id[i*W +: W] = W'($urandom);
                src_value[i*32 +: 32] = $urandom;
            end
            step();
        end
        drain("drain_random");
        check("end_idle", cdb_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
